// File: rtl/reset_seq_if.sv
// ----------------------------------------------------------------------------
// reset_seq_if
// Bundles the bring-up sequencer's handshake and status signals.
//
//   rst_req          soft bring-up restart request (level)
//   sdram_init_done  SDRAM controller init complete (asynchronous)
//   cam_cfg_done     camera configuration complete (asynchronous)
//   sdram_rst_n      active-low reset to the SDRAM controller
//   cam_rst_n        active-low reset to the camera path
//   disp_rst_n       active-low reset to the display path
//   sys_ready        high only while the system is running
//   fault            high only in the terminal fault state
//   retry_cnt        number of failed bring-ups (saturating)
//   state            current sequencer state encoding
//
// master: the side that raises requests/done flags and observes status.
// slave : the sequencer itself.
// ----------------------------------------------------------------------------
interface reset_seq_if;
    logic       rst_req;
    logic       sdram_init_done;
    logic       cam_cfg_done;
    logic       sdram_rst_n;
    logic       cam_rst_n;
    logic       disp_rst_n;
    logic       sys_ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    modport master (
        output rst_req, sdram_init_done, cam_cfg_done,
        input  sdram_rst_n, cam_rst_n, disp_rst_n, sys_ready, fault,
               retry_cnt, state
    );

    modport slave (
        input  rst_req, sdram_init_done, cam_cfg_done,
        output sdram_rst_n, cam_rst_n, disp_rst_n, sys_ready, fault,
               retry_cnt, state
    );
endinterface

// File: rtl/reset_seq.sv
// ----------------------------------------------------------------------------
// reset_seq
// Board-level power-up / reset sequencer. Holds every downstream block in
// reset, waits for power to settle, then releases SDRAM, camera and display
// resets in order, each gated by the previous stage's init-done handshake.
// A stage that never reports done (or a done flag that drops while running)
// costs one retry; after MAX_RETRY failures the sequencer parks in FAULT.
//
// Ports:
//   clk_100  100 MHz system clock
//   rst_n    synchronous active-low reset
//   bus      reset_seq_if.slave: rst_req, done inputs, reset/status outputs
//
// State encoding: HOLD=0 PWR=1 SDRAM=2 CAM=3 DISP=4 RUN=5 FAULT=6.
// ----------------------------------------------------------------------------
module reset_seq #(
    parameter int HOLD_CYC  = 100,
    parameter int PWR_WAIT  = 20000,
    parameter int TIMEOUT   = 1000000,
    parameter int MAX_RETRY = 3,
    parameter int DISP_WAIT = 16
) (
    input  logic        clk_100,
    input  logic        rst_n,
    reset_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_PWR   = 3'd1,
        ST_SDRAM = 3'd2,
        ST_CAM   = 3'd3,
        ST_DISP  = 3'd4,
        ST_RUN   = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    // Terminal counts: the counter starts at 0 on entry, so N cycles end at N-1.
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);
    localparam logic [31:0] PWR_LAST  = 32'(PWR_WAIT - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);
    localparam logic [31:0] DISP_LAST = 32'(DISP_WAIT - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

    // Output pattern {sdram_rst_n, cam_rst_n, disp_rst_n, sys_ready, fault}
    function automatic logic [4:0] out_decode(input state_t st);
        logic [4:0] pat;
        case (st)
            ST_HOLD:  pat = 5'b00000;
            ST_PWR:   pat = 5'b00000;
            ST_SDRAM: pat = 5'b10000;
            ST_CAM:   pat = 5'b11000;
            ST_DISP:  pat = 5'b11100;
            ST_RUN:   pat = 5'b11110;
            ST_FAULT: pat = 5'b00001;
            default:  pat = 5'b00000;
        endcase
        return pat;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] cnt_r;
    logic        cnt_clr_s;
    logic [1:0]  retry_r;
    logic [1:0]  retry_nxt_s;
    logic [1:0]  retry_inc_s;
    logic        retry_take_s;
    logic        sd_meta_r;
    logic        sd_sync_r;
    logic        cam_meta_r;
    logic        cam_sync_r;
    logic [4:0]  out_nxt_s;
    logic [4:0]  out_r;

    // Two-flop synchronizers for the asynchronous done flags
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            sd_meta_r  <= 1'b0;
            sd_sync_r  <= 1'b0;
            cam_meta_r <= 1'b0;
            cam_sync_r <= 1'b0;
        end else begin
            sd_meta_r  <= bus.sdram_init_done;
            sd_sync_r  <= sd_meta_r;
            cam_meta_r <= bus.cam_cfg_done;
            cam_sync_r <= cam_meta_r;
        end
    end

    // Saturating increment; FAULT is entered at the saturation value anyway
    assign retry_inc_s = (retry_r == RETRY_MAX) ? retry_r : (retry_r + 2'd1);

    // Next-state and retry bookkeeping
    always_comb begin
        state_nxt_s  = state_r;
        retry_nxt_s  = retry_r;
        retry_take_s = 1'b0;
        if (bus.rst_req) begin
            state_nxt_s = ST_HOLD;
            retry_nxt_s = 2'd0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) state_nxt_s = ST_PWR;
                    else                    state_nxt_s = ST_HOLD;
                end
                ST_PWR: begin
                    if (cnt_r == PWR_LAST) state_nxt_s = ST_SDRAM;
                    else                   state_nxt_s = ST_PWR;
                end
                ST_SDRAM: begin
                    // done wins over a timeout landing on the same cycle
                    if (sd_sync_r)              state_nxt_s  = ST_CAM;
                    else if (cnt_r == TO_LAST)  retry_take_s = 1'b1;
                    else                        state_nxt_s  = ST_SDRAM;
                end
                ST_CAM: begin
                    if (cam_sync_r)             state_nxt_s  = ST_DISP;
                    else if (cnt_r == TO_LAST)  retry_take_s = 1'b1;
                    else                        state_nxt_s  = ST_CAM;
                end
                ST_DISP: begin
                    if (cnt_r == DISP_LAST) state_nxt_s = ST_RUN;
                    else                    state_nxt_s = ST_DISP;
                end
                ST_RUN: begin
                    if (!sd_sync_r || !cam_sync_r) retry_take_s = 1'b1;
                    else                           state_nxt_s  = ST_RUN;
                end
                ST_FAULT: begin
                    state_nxt_s = ST_FAULT;
                end
                default: begin
                    state_nxt_s = ST_HOLD;
                end
            endcase

            if (retry_take_s) begin
                retry_nxt_s = retry_inc_s;
                if (retry_inc_s == RETRY_MAX) state_nxt_s = ST_FAULT;
                else                          state_nxt_s = ST_HOLD;
            end else begin
                retry_nxt_s = retry_r;
            end
        end
    end

    // A restart request re-enters HOLD even from HOLD, so it also clears the count
    assign cnt_clr_s = bus.rst_req | (state_nxt_s != state_r);
    assign out_nxt_s = out_decode(state_nxt_s);

    // State, counter, retry count and outputs all update on the same edge
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            state_r <= ST_HOLD;
            cnt_r   <= 32'd0;
            retry_r <= 2'd0;
            out_r   <= 5'b00000;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_clr_s ? 32'd0 : (cnt_r + 32'd1);
            retry_r <= retry_nxt_s;
            out_r   <= out_nxt_s;
        end
    end

    assign bus.sdram_rst_n = out_r[4];
    assign bus.cam_rst_n   = out_r[3];
    assign bus.disp_rst_n  = out_r[2];
    assign bus.sys_ready   = out_r[1];
    assign bus.fault       = out_r[0];
    assign bus.retry_cnt   = retry_r;
    assign bus.state       = state_r;

endmodule

// File: tb/tb_reset_seq.sv
// ----------------------------------------------------------------------------
// tb_reset_seq
// Self-checking bench for reset_seq with short timing parameters. A
// behavioural model tracks time-in-state against dwell limits and feeds the
// done flags through a two-sample history; every scenario compares the DUT
// against it each cycle, plus absolute timing points for the key scenarios.
// ----------------------------------------------------------------------------
module tb_reset_seq;

    localparam int P_HOLD  = 4;
    localparam int P_PWR   = 8;
    localparam int P_TO    = 32;
    localparam int P_RETRY = 3;
    localparam int P_DISP  = 2;

    logic clk_100;
    logic rst_n;
    logic rst_req;
    logic sd_in;
    logic cam_in;

    reset_seq_if bus ();

    assign bus.rst_req         = rst_req;
    assign bus.sdram_init_done = sd_in;
    assign bus.cam_cfg_done    = cam_in;

    reset_seq #(
        .HOLD_CYC (P_HOLD),
        .PWR_WAIT (P_PWR),
        .TIMEOUT  (P_TO),
        .MAX_RETRY(P_RETRY),
        .DISP_WAIT(P_DISP)
    ) dut (
        .clk_100(clk_100),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    logic [9:0] obs;
    assign obs = {bus.state, bus.retry_cnt, bus.sdram_rst_n, bus.cam_rst_n,
                  bus.disp_rst_n, bus.sys_ready, bus.fault};

    int tests_run;
    int tests_failed;
    int cyc;            // edges seen with rst_n=1; output first seen after edge N is "cycle N"

    // ---------------- reference model ----------------
    int m_state;        // 0 HOLD,1 PWR,2 SDRAM,3 CAM,4 DISP,5 RUN,6 FAULT
    int m_elapsed;      // cycles already spent in the current state
    int m_retry;
    bit sd_hist[2];     // [0] sampled last edge, [1] two edges ago
    bit cam_hist[2];

    function automatic int dwell(input int st);
        case (st)
            0:       return P_HOLD;
            1:       return P_PWR;
            4:       return P_DISP;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        bit sd_seen, cam_seen, fail_now;
        int nxt;
        if (!rst_n) begin
            m_state = 0; m_elapsed = 0; m_retry = 0;
            sd_hist = '{1'b0, 1'b0}; cam_hist = '{1'b0, 1'b0};
            return;
        end
        sd_seen  = sd_hist[1];
        cam_seen = cam_hist[1];
        sd_hist[1]  = sd_hist[0];  sd_hist[0]  = sd_in;
        cam_hist[1] = cam_hist[0]; cam_hist[0] = cam_in;
        nxt = m_state;
        fail_now = 1'b0;
        if (rst_req) begin
            m_retry = 0;
            m_state = 0;
            m_elapsed = 0;
            return;
        end
        if (m_state == 0 || m_state == 1 || m_state == 4) begin
            if (m_elapsed + 1 == dwell(m_state)) nxt = m_state + 1;
        end else if (m_state == 2) begin
            if (sd_seen) nxt = 3;
            else if (m_elapsed + 1 == P_TO) fail_now = 1'b1;
        end else if (m_state == 3) begin
            if (cam_seen) nxt = 4;
            else if (m_elapsed + 1 == P_TO) fail_now = 1'b1;
        end else if (m_state == 5) begin
            if (!sd_seen || !cam_seen) fail_now = 1'b1;
        end
        if (fail_now) begin
            if (m_retry < P_RETRY) m_retry = m_retry + 1;
            nxt = (m_retry == P_RETRY) ? 6 : 0;
        end
        m_elapsed = (nxt != m_state) ? 0 : m_elapsed + 1;
        m_state = nxt;
    endtask

    function automatic logic [9:0] exp_vec();
        logic sd, cm, dp, rd, fl;
        sd = (m_state >= 2 && m_state <= 5);
        cm = (m_state >= 3 && m_state <= 5);
        dp = (m_state == 4 || m_state == 5);
        rd = (m_state == 5);
        fl = (m_state == 6);
        return {3'(m_state), 2'(m_retry), sd, cm, dp, rd, fl};
    endfunction

    // One clock: model follows the edge, DUT observed at the falling edge
    task automatic tick();
        @(posedge clk_100);
        model_step();
        @(negedge clk_100);
        if (rst_n) cyc = cyc + 1;
        else       cyc = 0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        rst_req = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sd_in = 1'($urandom_range(0, 1));
        cam_in = 1'($urandom_range(0, 1));
        rst_req = 1'($urandom_range(0, 1));
        rst_n = 1'b0;
        repeat (2 + $urandom_range(0, 3)) tick();
        tests_run++;
        if (obs !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_state got=%b exp=%b", obs, 10'd0);
        end
        tests_run++;
        if (obs !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_model got=%b exp=%b", obs, exp_vec());
        end
        rst_req = 1'b0;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_normal();
        int f_sd, f_cam, f_disp, f_rdy;
        sd_in = 1'b1; cam_in = 1'b1;
        do_reset(2 + $urandom_range(0, 3));
        f_sd = -1; f_cam = -1; f_disp = -1; f_rdy = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL normal_cycle%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
            if (bus.sdram_rst_n === 1'b1 && f_sd < 0)  f_sd = cyc;
            if (bus.cam_rst_n === 1'b1 && f_cam < 0)   f_cam = cyc;
            if (bus.disp_rst_n === 1'b1 && f_disp < 0) f_disp = cyc;
            if (bus.sys_ready === 1'b1 && f_rdy < 0)   f_rdy = cyc;
        end
        tests_run++;
        if (f_sd != 12) begin tests_failed++; $display("FAIL normal_sdram_rel got=%0d exp=12", f_sd); end
        tests_run++;
        if (f_cam != 13) begin tests_failed++; $display("FAIL normal_cam_rel got=%0d exp=13", f_cam); end
        tests_run++;
        if (f_disp != 14) begin tests_failed++; $display("FAIL normal_disp_rel got=%0d exp=14", f_disp); end
        tests_run++;
        if (f_rdy != 16) begin tests_failed++; $display("FAIL normal_ready got=%0d exp=16", f_rdy); end
    endtask

    task automatic test_sdram_timeout();
        int r1, r2, flt, attempt;
        attempt = P_HOLD + P_PWR + P_TO;
        sd_in = 1'b0; cam_in = 1'b1;
        do_reset(2);
        r1 = -1; r2 = -1; flt = -1;
        for (int i = 0; i < 300 && flt < 0; i++) begin
            tick();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL timeout_cycle%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
            if (bus.retry_cnt === 2'd1 && r1 < 0) r1 = cyc;
            if (bus.retry_cnt === 2'd2 && r2 < 0) r2 = cyc;
            if (bus.fault === 1'b1) flt = cyc;
        end
        tests_run++;
        if (r1 != attempt) begin tests_failed++; $display("FAIL retry1_time got=%0d exp=%0d", r1, attempt); end
        tests_run++;
        if (r2 != 2 * attempt) begin tests_failed++; $display("FAIL retry2_time got=%0d exp=%0d", r2, 2 * attempt); end
        tests_run++;
        if (flt != 3 * attempt) begin tests_failed++; $display("FAIL fault_time got=%0d exp=%0d", flt, 3 * attempt); end
        repeat (10) tick();
        tests_run++;
        if (obs !== {3'd6, 2'd3, 5'b00001}) begin
            tests_failed++;
            $display("FAIL fault_hold got=%b exp=%b", obs, {3'd6, 2'd3, 5'b00001});
        end
    endtask

    // Restart request, then count edges until sys_ready
    task automatic restart_and_time(input string tag);
        int rdy;
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        tests_run++;
        if (obs !== 10'd0) begin
            tests_failed++;
            $display("FAIL %s_next got=%b exp=%b", tag, obs, 10'd0);
        end
        rdy = -1;
        for (int k = 1; k <= 40 && rdy < 0; k++) begin
            tick();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL %s_cycle%0d got=%b exp=%b", tag, k, obs, exp_vec());
            end
            if (bus.sys_ready === 1'b1) rdy = k;
        end
        tests_run++;
        if (rdy != 16) begin tests_failed++; $display("FAIL %s_ready got=%0d exp=16", tag, rdy); end
    endtask

    task automatic test_rst_req_fault();
        sd_in = 1'b1; cam_in = 1'b1;
        restart_and_time("rstreq_fault");
    endtask

    task automatic test_rst_req_run();
        repeat (1 + $urandom_range(0, 8)) tick();
        restart_and_time("rstreq_run");
    endtask

    task automatic test_run_drop();
        int drop_k;
        repeat (1 + $urandom_range(0, 8)) tick();
        sd_in = 1'b0;
        drop_k = -1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL drop_cycle%0d got=%b exp=%b", k, obs, exp_vec());
            end
            if (drop_k < 0 && obs[6:1] === 6'b010000) drop_k = k;
        end
        tests_run++;
        if (drop_k < 1 || drop_k > 3) begin
            tests_failed++;
            $display("FAIL drop_latency got=%0d exp=1..3", drop_k);
        end
        tests_run++;
        if (bus.retry_cnt !== 2'd1) begin
            tests_failed++;
            $display("FAIL drop_retry got=%0d exp=1", bus.retry_cnt);
        end
        sd_in = 1'b1;
    endtask

    task automatic test_timeout_coincide();
        int guard;
        sd_in = 1'b1; cam_in = 1'b0;
        do_reset(2);
        guard = 0;
        while (m_state != 3 && guard < 50) begin
            tick();
            guard++;
        end
        tests_run++;
        if (m_state != 3 || obs !== exp_vec()) begin
            tests_failed++;
            $display("FAIL coincide_entry got=%b exp=%b", obs, exp_vec());
        end
        for (int k = 1; k <= 33; k++) begin
            if (k == 30) cam_in = 1'b1;   // first sampled high two edges before the last CAM cycle
            tick();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL coincide_cycle%0d got=%b exp=%b", k, obs, exp_vec());
            end
            if (k == 31) begin
                tests_run++;
                if (bus.state !== 3'd3) begin tests_failed++; $display("FAIL coincide_pre got=%0d exp=3", bus.state); end
            end
            if (k == 32) begin
                tests_run++;
                if (bus.state !== 3'd4 || bus.retry_cnt !== 2'd0) begin
                    tests_failed++;
                    $display("FAIL coincide_disp got=%0d/%0d exp=4/0", bus.state, bus.retry_cnt);
                end
            end
        end
    endtask

    task automatic test_rst_n_mid();
        int guard, f_sd, f_rdy;
        sd_in = 1'b1; cam_in = 1'b0;
        do_reset(2);
        guard = 0;
        while (m_state != 3 && guard < 50) begin tick(); guard++; end
        repeat (1 + $urandom_range(0, 10)) tick();
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (obs !== 10'd0) begin tests_failed++; $display("FAIL rstn_mid got=%b exp=%b", obs, 10'd0); end
        rst_n = 1'b1; cam_in = 1'b1; cyc = 0;
        f_sd = -1; f_rdy = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL rstn_cycle%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
            if (bus.sdram_rst_n === 1'b1 && f_sd < 0) f_sd = cyc;
            if (bus.sys_ready === 1'b1 && f_rdy < 0)  f_rdy = cyc;
        end
        tests_run++;
        if (f_sd != 12) begin tests_failed++; $display("FAIL rstn_sdram got=%0d exp=12", f_sd); end
        tests_run++;
        if (f_rdy != 16) begin tests_failed++; $display("FAIL rstn_ready got=%0d exp=16", f_rdy); end
    endtask

    task automatic test_random();
        sd_in = 1'b1; cam_in = 1'b1;
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) sd_in  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) cam_in = ($urandom_range(0, 3) != 0);
            rst_req = ($urandom_range(0, 299) == 0);
            rst_n   = ($urandom_range(0, 799) != 0);
            tick();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random_cycle%0d got=%b exp=%b", i, obs, exp_vec());
            end
        end
        rst_req = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        cyc = 0;
        rst_n = 1'b0; rst_req = 1'b0; sd_in = 1'b0; cam_in = 1'b0;
        m_state = 0; m_elapsed = 0; m_retry = 0;
        sd_hist = '{1'b0, 1'b0}; cam_hist = '{1'b0, 1'b0};
        test_reset();
        test_normal();
        test_sdram_timeout();
        test_rst_req_fault();
        test_rst_req_run();
        test_run_drop();
        test_timeout_coincide();
        test_rst_n_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
